// File: rtl/mem_access.sv
//==============================================================================
// Module  : mem_access
// Brief   : Load/store stage: aligns accesses onto a 64-bit data bus, extends
//           load results and produces a registered writeback or error pulse.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [63:0] addr_mem_rd,
    input  logic [63:0] addr_mem_wr,
    input  logic [63:0] data_mem_wr,
    input  logic [2:0]  load_code,
    input  logic [1:0]  store_code,
    input  logic [63:0] alu_result,
    input  logic [4:0]  rd_addr,
    input  logic        rd_wr_en,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [63:0] bus_rdata,
    output logic        stall_req,
    output logic        wb_valid,
    output logic        wb_wr_en,
    output logic [4:0]  wb_rd_addr,
    output logic [63:0] wb_data,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int c_CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(WAIT_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [63:0]         r_addr;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_we;
    logic [63:0]         r_wdata;
    logic [7:0]          r_wstrb;
    logic [4:0]          r_rd_addr;
    logic                r_rd_wr_en;

    logic                w_is_store;
    logic                w_is_load;
    logic                w_mem_op;
    logic [1:0]          w_size;
    logic                w_signed;
    logic [63:0]         w_addr;
    logic                w_misalign;
    logic [7:0]          w_strb;
    logic [63:0]         w_field;
    logic [63:0]         w_load;

    // A load with load_code 000 carries no access and is treated as an ALU op.
    assign w_is_store = mem_wr_en;
    assign w_is_load  = !mem_wr_en && mem_rd_en && (load_code != 3'd0);
    assign w_mem_op   = w_is_store || w_is_load;
    assign w_addr     = w_is_store ? addr_mem_wr : addr_mem_rd;
    assign w_signed   = w_is_load && (load_code inside {3'd1, 3'd2, 3'd3});

    // Size encoding: 0 byte, 1 half, 2 word, 3 double.
    always_comb begin
        w_size = 2'd3;
        if (w_is_store) begin
            w_size = store_code;
        end else begin
            case (load_code)
                3'd1, 3'd5: w_size = 2'd0;
                3'd2, 3'd6: w_size = 2'd1;
                3'd3, 3'd7: w_size = 2'd2;
                default:    w_size = 2'd3;
            endcase
        end
    end

    always_comb begin
        w_misalign = 1'b0;
        w_strb     = 8'h01;
        case (w_size)
            2'd0: begin
                w_misalign = 1'b0;
                w_strb     = 8'h01;
            end
            2'd1: begin
                w_misalign = w_addr[0];
                w_strb     = 8'h03;
            end
            2'd2: begin
                w_misalign = |w_addr[1:0];
                w_strb     = 8'h0F;
            end
            default: begin
                w_misalign = |w_addr[2:0];
                w_strb     = 8'hFF;
            end
        endcase
    end

    assign w_field = bus_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_load = w_field;
        case (r_size)
            2'd0:    w_load = {{56{r_signed & w_field[7]}},  w_field[7:0]};
            2'd1:    w_load = {{48{r_signed & w_field[15]}}, w_field[15:0]};
            2'd2:    w_load = {{32{r_signed & w_field[31]}}, w_field[31:0]};
            default: w_load = w_field;
        endcase
    end

    // Bus signals are decoded from latched state so they hold steady until acceptance.
    assign bus_req   = (r_state == S_BUSY);
    assign bus_we    = bus_req && r_we;
    assign bus_addr  = bus_req ? {r_addr[63:3], 3'b000} : 64'd0;
    assign bus_wdata = bus_req ? r_wdata : 64'd0;
    assign bus_wstrb = bus_req ? r_wstrb : 8'h00;

    always_comb begin
        stall_req = 1'b0;
        if (rst_n) begin
            if (r_state == S_IDLE) begin
                stall_req = in_valid && w_mem_op && !w_misalign;
            end else begin
                stall_req = !bus_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= 64'd0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= 64'd0;
            r_wstrb      <= 8'h00;
            r_rd_addr    <= 5'd0;
            r_rd_wr_en   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_wr_en     <= 1'b0;
            wb_rd_addr   <= 5'd0;
            wb_data      <= 64'd0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_wr_en     <= 1'b0;
            wb_rd_addr   <= 5'd0;
            wb_data      <= 64'd0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!w_mem_op) begin
                            wb_valid   <= 1'b1;
                            wb_wr_en   <= rd_wr_en;
                            wb_rd_addr <= rd_addr;
                            wb_data    <= alu_result;
                        end else if (w_misalign) begin
                            wb_valid     <= 1'b1;
                            wb_rd_addr   <= rd_addr;
                            misalign_err <= 1'b1;
                        end else begin
                            r_state    <= S_BUSY;
                            r_cnt      <= '0;
                            r_addr     <= w_addr;
                            r_size     <= w_size;
                            r_signed   <= w_signed;
                            r_we       <= w_is_store;
                            r_wdata    <= w_is_store ? (data_mem_wr << {w_addr[2:0], 3'b000}) : 64'd0;
                            r_wstrb    <= w_is_store ? (w_strb << w_addr[2:0]) : 8'h00;
                            r_rd_addr  <= rd_addr;
                            r_rd_wr_en <= rd_wr_en;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus_ready) begin
                        r_state    <= S_IDLE;
                        wb_valid   <= 1'b1;
                        wb_rd_addr <= r_rd_addr;
                        if (!r_we) begin
                            wb_wr_en <= r_rd_wr_en;
                            wb_data  <= w_load;
                        end
                    end else if (r_cnt == c_LIMIT) begin
                        r_state     <= S_IDLE;
                        wb_valid    <= 1'b1;
                        wb_rd_addr  <= r_rd_addr;
                        timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
